prmcu_uart_tx_arbiter: RTL

- Shares the single UART transmit input stream (the in_dat/in_vld/in_rdy port of prmcu_uart_top) between N_REQ independent requesters.
- Arbitration is round-robin with bounded bursts: the grant is held for up to MAX_BURST accepted words, then passed on.
- Sits between requester logic (CPU register interface, DMA, debug) and the UART top; the granted requester's data passes combinationally to the UART.

---
 rtl/prmcu_uart_tx_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/prmcu_uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART transmit stream among N_REQ requesters.
// A grant lasts at most MAX_BURST accepted words; the granted requester passes straight through.
module prmcu_uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int DAT_W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_en_i,
  input  logic [N_REQ*DAT_W-1:0]   req_dat_i,
  input  logic [N_REQ-1:0]         req_vld_i,
  output logic [N_REQ-1:0]         req_rdy_o,
  output logic [DAT_W-1:0]         out_dat_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_idx_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;

  logic [DAT_W-1:0] w_req_dat [N_REQ];
  logic             w_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W:0]   w_cand;
  logic             w_gnt_vld;
  logic             w_hs;
  logic             w_last_beat;
  logic             w_release;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_req_dat[k] = req_dat_i[k*DAT_W +: DAT_W];
    end
  end

  // r_grant_idx doubles as last_grant: the scan starts one past it and wraps.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = {1'b0, r_grant_idx} + (IDX_W+1)'(off);
      if (w_cand >= (IDX_W+1)'(N_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(N_REQ);
      end
      if (!w_found && req_vld_i[w_cand[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_gnt_vld   = (r_state == ST_GRANT) && req_vld_i[r_grant_idx];
  assign w_hs        = w_gnt_vld && out_rdy_i;
  assign w_last_beat = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release   = (r_state == ST_GRANT) &&
                       ((w_hs && w_last_beat) || !w_gnt_vld || !arb_en_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= IDX_W'(N_REQ - 1);
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Release always lands in IDLE, which gives exactly one bubble between grants.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_burst_cnt_nxt = r_burst_cnt;
    out_dat_o       = '0;
    out_vld_o       = 1'b0;
    req_rdy_o       = '0;
    case (r_state)
      ST_IDLE: begin
        if (arb_en_i && w_found) begin
          w_state_nxt     = ST_GRANT;
          w_grant_nxt     = N_REQ'(1) << w_sel_idx;
          w_grant_idx_nxt = w_sel_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        out_dat_o = w_req_dat[r_grant_idx];
        out_vld_o = w_gnt_vld;
        req_rdy_o = r_grant & {N_REQ{out_rdy_i}};
        if (w_release) begin
          w_state_nxt     = ST_IDLE;
          w_grant_nxt     = '0;
          w_burst_cnt_nxt = '0;
        end else if (w_hs) begin
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign grant_o     = r_grant;
  assign grant_idx_o = r_grant_idx;
  assign busy_o      = (r_state == ST_GRANT);

endmodule
